// File: rtl/rm_feeder_pkg.sv
// Shared definitions for the symbol feeder: default parameters, the idle
// symbol code and the drain FSM state type.
package rm_feeder_pkg;

  localparam int         DEF_EVT_W      = 16;
  localparam int         DEF_FIFO_DEPTH = 4;
  localparam logic [7:0] DEF_SYM_BASE   = 8'h01;

  // Symbol code driven on idle ticks when RM_FEEDER_IDLE_SYM_EN is defined
  localparam logic [7:0] IDLE_SYM = 8'h00;

  // IDLE: work register empty; DRAIN: work register still holds set bits
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/rm_feeder_fifo.sv
// Small synchronous FIFO holding pending event vectors for the feeder.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate counter. A push and a pop in the same cycle at full are both
// honoured; the caller decides when a push is legal.
module rm_feeder_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  // Read and write pointers advance independently on pop and push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/rm_symbol_feeder.sv
// Converts per-cycle event bit vectors into a serial stream of symbol codes
// for runtime-monitor clusters. Nonzero vectors are queued, then each set bit
// is emitted as SYM_BASE + bit index, lowest bit first, one per cycle.
// Vectors arriving while the queue is full are dropped and counted.
// Optional build macro RM_FEEDER_IDLE_SYM_EN: cycles with nothing to emit
// produce an idle tick (symbols = IDLE_SYM, run = 1) instead of run = 0.
module rm_symbol_feeder
  import rm_feeder_pkg::*;
#(
  parameter int         EVT_W      = DEF_EVT_W,
  parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [7:0] SYM_BASE   = DEF_SYM_BASE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evt_valid,
  input  logic [EVT_W-1:0] evt_vec,
  input  logic             clr_ovf,
  output logic [7:0]       symbols,
  output logic             run,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam logic [EVT_W-1:0] VEC_ONE = 1;

  feeder_state_t    r_state;
  logic [EVT_W-1:0] r_work;
  logic [7:0]       r_symbols;
  logic             r_run;
  logic             r_overflow;
  logic [7:0]       r_dropCnt;

  logic [EVT_W-1:0] w_fifoHead;
  logic             w_fifoFull;
  logic             w_fifoEmpty;
  logic             w_haveWork;
  logic             w_hasSrc;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_evtNonzero;
  logic [EVT_W-1:0] w_src;
  logic [EVT_W-1:0] w_rest;
  logic [7:0]       w_idx;

  rm_feeder_fifo #(
    .W     (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (evt_vec),
    .o_data  (w_fifoHead),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  // Source selection, queue push/drop decision and lowest-set-bit extraction
  always_comb begin
    w_haveWork   = (r_state == DRAIN);
    w_pop        = !w_haveWork && !w_fifoEmpty;
    w_hasSrc     = w_haveWork || !w_fifoEmpty;
    w_src        = w_haveWork ? r_work : (w_fifoEmpty ? '0 : w_fifoHead);
    w_rest       = w_src & (w_src - VEC_ONE);
    w_evtNonzero = |evt_vec;
    w_push       = evt_valid && w_evtNonzero && (!w_fifoFull || w_pop);
    w_drop       = evt_valid && w_evtNonzero && w_fifoFull && !w_pop;
    w_idx        = 8'h00;
    for (int i = EVT_W - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        w_idx = 8'(i);
      end
    end
  end

  // Drain FSM: emit one symbol per cycle from the work register or queue head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_symbols <= 8'h00;
      r_run     <= 1'b0;
    end else if (w_hasSrc) begin
      r_symbols <= SYM_BASE + w_idx;
      r_run     <= 1'b1;
      r_work    <= w_rest;
      r_state   <= (w_rest != '0) ? DRAIN : IDLE;
    end else begin
`ifdef RM_FEEDER_IDLE_SYM_EN
      r_symbols <= IDLE_SYM;
      r_run     <= 1'b1;
`else
      r_run     <= 1'b0;
`endif
      r_work    <= '0;
      r_state   <= IDLE;
    end
  end

  // Overflow bookkeeping; a drop in the same cycle as a clear takes priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= 8'h00;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_dropCnt <= 8'h01;
      end else if (r_dropCnt != 8'hFF) begin
        r_dropCnt <= r_dropCnt + 8'h01;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= 8'h00;
    end
  end

  assign symbols  = r_symbols;
  assign run      = r_run;
  assign overflow = r_overflow;
  assign drop_cnt = r_dropCnt;

endmodule

// File: tb/tb_rm_symbol_feeder.sv
// Directed testbench for rm_symbol_feeder with hand-computed expectations.
// Works in both builds: run on no-source cycles is expected to equal IDLE_EN.
module tb_rm_symbol_feeder;

`ifdef RM_FEEDER_IDLE_SYM_EN
  localparam logic IDLE_EN = 1'b1;
`else
  localparam logic IDLE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        evt_valid;
  logic [15:0] evt_vec;
  logic        clr_ovf;
  logic [7:0]  symbols;
  logic        run;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int testCount = 0;
  int failCount = 0;
  int symCount;
  int strayCount;

  rm_symbol_feeder #(
    .EVT_W      (16),
    .FIFO_DEPTH (4),
    .SYM_BASE   (8'h01)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .evt_valid (evt_valid),
    .evt_vec   (evt_vec),
    .clr_ovf   (clr_ovf),
    .symbols   (symbols),
    .run       (run),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive the inputs for the current cycle
  task automatic applyStimulus(input logic v, input logic [15:0] vec, input logic clr);
    evt_valid = v;
    evt_vec   = vec;
    clr_ovf   = clr;
  endtask

  // Advance to just after the next rising edge, where outputs are stable
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset and leave the bench at the start of a fresh cycle 0
  task automatic resetDut();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stepCycle();
  endtask

  initial begin
    // Reset values while reset is held from time zero
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    #1;
    checkOutput("rst_symbols", {24'h0, symbols}, 32'h00);
    checkOutput("rst_run", {31'h0, run}, 32'h0);
    checkOutput("rst_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("rst_drop_cnt", {24'h0, drop_cnt}, 32'h00);

    // No events after reset: idle behaviour
    resetDut();
    stepCycle();
    checkOutput("idle_run", {31'h0, run}, {31'h0, IDLE_EN});
    checkOutput("idle_symbols", {24'h0, symbols}, 32'h00);

    // Single vector 0x0005: symbols 01, 03, then no source
    applyStimulus(1'b1, 16'h0005, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    stepCycle();
    checkOutput("v5_c2_sym", {24'h0, symbols}, 32'h01);
    checkOutput("v5_c2_run", {31'h0, run}, 32'h1);
    stepCycle();
    checkOutput("v5_c3_sym", {24'h0, symbols}, 32'h03);
    checkOutput("v5_c3_run", {31'h0, run}, 32'h1);
    stepCycle();
    checkOutput("v5_c4_run", {31'h0, run}, {31'h0, IDLE_EN});

    // Back-to-back 0x0003 then 0x8000: 01, 02, 10 with no bubble
    resetDut();
    applyStimulus(1'b1, 16'h0003, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h8000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("b2b_c2_sym", {24'h0, symbols}, 32'h01);
    stepCycle();
    checkOutput("b2b_c3_sym", {24'h0, symbols}, 32'h02);
    checkOutput("b2b_c3_run", {31'h0, run}, 32'h1);
    stepCycle();
    checkOutput("b2b_c4_sym", {24'h0, symbols}, 32'h10);
    checkOutput("b2b_c4_run", {31'h0, run}, 32'h1);
    stepCycle();
    checkOutput("b2b_c5_run", {31'h0, run}, {31'h0, IDLE_EN});
    checkOutput("b2b_overflow", {31'h0, overflow}, 32'h0);

    // Sparse vector 0x8421: bits 0,5,10,15 -> 01, 06, 0B, 10
    resetDut();
    applyStimulus(1'b1, 16'h8421, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    stepCycle();
    checkOutput("v8421_s0", {24'h0, symbols}, 32'h01);
    stepCycle();
    checkOutput("v8421_s1", {24'h0, symbols}, 32'h06);
    stepCycle();
    checkOutput("v8421_s2", {24'h0, symbols}, 32'h0B);
    stepCycle();
    checkOutput("v8421_s3", {24'h0, symbols}, 32'h10);
    stepCycle();
    checkOutput("v8421_end_run", {31'h0, run}, {31'h0, IDLE_EN});

    // A valid zero vector is discarded: nothing emitted, nothing dropped
    resetDut();
    applyStimulus(1'b1, 16'h0000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    stepCycle();
    checkOutput("zero_c2_run", {31'h0, run}, {31'h0, IDLE_EN});
    stepCycle();
    checkOutput("zero_c3_run", {31'h0, run}, {31'h0, IDLE_EN});
    checkOutput("zero_drop_cnt", {24'h0, drop_cnt}, 32'h00);

    // Six 0xFFFF vectors into a depth-4 queue: one drop, 80 ascending symbols
    resetDut();
    symCount = 0;
    for (int c = 0; c < 110; c++) begin
      applyStimulus(c < 6, 16'hFFFF, 1'b0);
      if (run && symbols != 8'h00) begin
        checkOutput("ovf_sym_seq", {24'h0, symbols}, 32'(1 + symCount % 16));
        symCount++;
      end
      stepCycle();
    end
    checkOutput("ovf_sym_total", 32'(symCount), 32'd80);
    checkOutput("ovf_overflow", {31'h0, overflow}, 32'h1);
    checkOutput("ovf_drop_cnt", {24'h0, drop_cnt}, 32'h01);

    // Clear with no drop pending
    applyStimulus(1'b0, 16'h0000, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("clr_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("clr_drop_cnt", {24'h0, drop_cnt}, 32'h00);

    // Drops in cycles 5 and 6 with clear in cycle 6: the drop wins, count restarts at 1
    resetDut();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c < 7, 16'hFFFF, c == 6);
      if (c == 6) begin
        checkOutput("clrdrop_pre_cnt", {24'h0, drop_cnt}, 32'h01);
      end
      if (c == 7) begin
        checkOutput("clrdrop_overflow", {31'h0, overflow}, 32'h1);
        checkOutput("clrdrop_cnt", {24'h0, drop_cnt}, 32'h01);
      end
      stepCycle();
    end

    // Hundreds of drops saturate the counter at 0xFF
    resetDut();
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'b1, 16'hFFFF, 1'b0);
      stepCycle();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("sat_drop_cnt", {24'h0, drop_cnt}, 32'hFF);
    checkOutput("sat_overflow", {31'h0, overflow}, 32'h1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("sat_clr_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("sat_clr_drop_cnt", {24'h0, drop_cnt}, 32'h00);

    // Reset in the middle of draining 0x00FF, after symbols 01, 02, 03
    resetDut();
    applyStimulus(1'b1, 16'h00FF, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("midrst_pre_sym", {24'h0, symbols}, 32'h03);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_run", {31'h0, run}, 32'h0);
    checkOutput("midrst_symbols", {24'h0, symbols}, 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    strayCount = 0;
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      if (run && symbols != 8'h00) begin
        strayCount++;
      end
    end
    checkOutput("midrst_no_syms", 32'(strayCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
